riscv_regfile_mp: RTL and testbench

RISCV_REGFILE_MP -- requirements
Module: riscv_regfile_mp

---
 rtl/riscv_regfile_mp.sv | 139 +++++++++++++
 tb/tb_riscv_regfile_mp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile_mp.sv
// Multi-ported RISC-V register file with optional FP bank, per-entry busy
// (scoreboard) bits, reservation-conflict pulse and optional write bypass.

module riscv_regfile_mp_rd #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WRITE   = 2,
    parameter int NUM_ENTRIES = 32,
    parameter int BYPASS      = 0
) (
    input  logic                                   rst_n,
    input  logic [ADDR_WIDTH-1:0]                  raddr_i,
    input  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] mem_i,
    input  logic [NUM_ENTRIES-1:0]                 busy_i,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]        waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]        wdata_i,
    input  logic [NUM_WRITE-1:0]                   we_i,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic                                   busy_o
);

    logic hit;

    always_comb begin
        rdata_o = '0;
        busy_o  = 1'b0;
        hit     = 1'b0;
        // Entry 0 is held at zero in storage, so it needs no special case here.
        // Addresses beyond the implemented bank match nothing and read as zero.
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (raddr_i == ADDR_WIDTH'(e)) begin
                hit     = 1'b1;
                rdata_o = mem_i[e];
                busy_o  = busy_i[e];
            end
        end
        if (BYPASS != 0 && hit && raddr_i != '0) begin
            // Ascending port order: the highest-index matching write wins.
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (we_i[w] && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr_i)
                    rdata_o = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (!rst_n) begin
            rdata_o = '0;
            busy_o  = 1'b0;
        end
    end

endmodule

module riscv_regfile_mp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 3,
    parameter int NUM_WRITE  = 2,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int BYPASS     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_READ-1:0]            busy_o,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WRITE-1:0]           we_i,
    input  logic                           rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]          rsv_addr_i,
    output logic                           rsv_conflict_o
);

    localparam int NUM_ENTRIES = (FPU != 0 && ZFINX == 0) ? 64 : 32;

    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [NUM_ENTRIES-1:0]                 busy_q, busy_d;
    logic                                   rsv_conflict_q, rsv_conflict_d;

    always_comb begin
        logic wr_hit;
        logic rsv_hit;
        mem_d          = mem_q;
        busy_d         = busy_q;
        rsv_conflict_d = 1'b0;
        wr_hit         = 1'b0;
        rsv_hit        = 1'b0;
        // Entry 0 is never updated, keeping it a constant zero.
        for (int e = 1; e < NUM_ENTRIES; e++) begin
            wr_hit = 1'b0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (we_i[w] && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e)) begin
                    wr_hit   = 1'b1;
                    mem_d[e] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            rsv_hit = rsv_valid_i && (rsv_addr_i == ADDR_WIDTH'(e));
            // Reserve is applied after clear so it wins on a same-cycle collision.
            if (wr_hit)  busy_d[e] = 1'b0;
            if (rsv_hit) busy_d[e] = 1'b1;
            if (rsv_hit && busy_q[e] && !wr_hit) rsv_conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q          <= '0;
            busy_q         <= '0;
            rsv_conflict_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            busy_q         <= busy_d;
            rsv_conflict_q <= rsv_conflict_d;
        end
    end

    assign rsv_conflict_o = rsv_conflict_q;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        riscv_regfile_mp_rd #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WRITE  (NUM_WRITE),
            .NUM_ENTRIES(NUM_ENTRIES),
            .BYPASS     (BYPASS)
        ) u_rd (
            .rst_n  (rst_n),
            .raddr_i(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_i  (mem_q),
            .busy_i (busy_q),
            .waddr_i(waddr_i),
            .wdata_i(wdata_i),
            .we_i   (we_i),
            .rdata_o(rdata_o[k*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o (busy_o[k])
        );
    end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench: dut0 = integer-only, no bypass; dut1 = FP bank with bypass.
module tb_riscv_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] raddr = '0;
    logic [11:0] waddr = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  we = '0;
    logic        rsv_valid = 1'b0;
    logic [5:0]  rsv_addr = '0;
    logic [95:0] rdata0, rdata1;
    logic [2:0]  busy0, busy1;
    logic        conf0, conf1;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    always #5 clk = ~clk;

    riscv_regfile_mp dut0 (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata0), .busy_o(busy0),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_conflict_o(conf0)
    );

    riscv_regfile_mp #(.FPU(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata1), .busy_o(busy1),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_conflict_o(conf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2);
        raddr = {a2, a1, a0};
    endtask

    task automatic test_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++;
            if (rdata0[k*32 +: 32] !== 32'h0 || rdata1[k*32 +: 32] !== 32'h0)
                $display("FAIL reset_rdata port%0d: got %h/%h want 0", k, rdata0[k*32 +: 32], rdata1[k*32 +: 32]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (busy0 !== 3'b0 || busy1 !== 3'b0 || conf0 !== 1'b0 || conf1 !== 1'b0)
            $display("FAIL reset_busy: got %b/%b conf %b/%b want 0", busy0, busy1, conf0, conf1);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        set_raddr(6'd5, 6'd5, 6'd5);
        waddr = {6'd0, 6'd5}; wdata = {32'h0, 32'hDEADBEEF}; we = 2'b01;
        #1;
        chk_cnt++;
        if (rdata0[31:0] !== 32'h0)
            $display("FAIL wr_before_commit: got %h want 00000000", rdata0[31:0]);
        else pass_cnt++;
        tick();
        we = 2'b00;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++;
            if (rdata0[k*32 +: 32] !== 32'hDEADBEEF || rdata1[k*32 +: 32] !== 32'hDEADBEEF)
                $display("FAIL wr_read port%0d: got %h/%h want deadbeef", k, rdata0[k*32 +: 32], rdata1[k*32 +: 32]);
            else pass_cnt++;
        end
        // Write to x0 must not stick.
        waddr = {6'd0, 6'd0}; wdata = {32'h0, 32'hFFFFFFFF}; we = 2'b01;
        set_raddr(6'd5, 6'd0, 6'd5);
        #1;
        chk_cnt++;
        if (rdata1[63:32] !== 32'h0)
            $display("FAIL x0_bypass: got %h want 00000000", rdata1[63:32]);
        else pass_cnt++;
        tick();
        we = 2'b00;
        #1;
        chk_cnt++;
        if (rdata0[63:32] !== 32'h0 || rdata1[63:32] !== 32'h0)
            $display("FAIL x0_read: got %h/%h want 00000000", rdata0[63:32], rdata1[63:32]);
        else pass_cnt++;
    endtask

    task automatic test_multi_write();
        set_raddr(6'd7, 6'd7, 6'd7);
        waddr = {6'd7, 6'd7}; wdata = {32'h2222, 32'h1111}; we = 2'b11;
        #1;
        chk_cnt++;
        if (rdata1[31:0] !== 32'h2222 || rdata0[31:0] !== 32'h0)
            $display("FAIL multi_bypass: got %h/%h want 00000000/00002222", rdata0[31:0], rdata1[31:0]);
        else pass_cnt++;
        tick();
        we = 2'b00;
        #1;
        chk_cnt++;
        if (rdata0[31:0] !== 32'h2222 || rdata1[31:0] !== 32'h2222)
            $display("FAIL multi_write: got %h/%h want 00002222", rdata0[31:0], rdata1[31:0]);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        waddr = {6'd0, 6'd9}; wdata = {32'h0, 32'h12345678}; we = 2'b01;
        tick();
        set_raddr(6'd9, 6'd9, 6'd9);
        wdata = {32'h0, 32'hA5A5A5A5};
        #1;
        chk_cnt++;
        if (rdata1[31:0] !== 32'hA5A5A5A5 || rdata0[31:0] !== 32'h12345678)
            $display("FAIL bypass_same_cycle: got %h/%h want 12345678/a5a5a5a5", rdata0[31:0], rdata1[31:0]);
        else pass_cnt++;
        tick();
        we = 2'b00;
        #1;
        chk_cnt++;
        if (rdata0[95:64] !== 32'hA5A5A5A5 || rdata1[95:64] !== 32'hA5A5A5A5)
            $display("FAIL bypass_commit: got %h/%h want a5a5a5a5", rdata0[95:64], rdata1[95:64]);
        else pass_cnt++;
    endtask

    task automatic test_busy();
        rsv_valid = 1'b1; rsv_addr = 6'd3;
        tick();
        rsv_valid = 1'b0;
        set_raddr(6'd3, 6'd5, 6'd3);
        #1;
        chk_cnt++;
        if (busy0 !== 3'b101 || busy1 !== 3'b101)
            $display("FAIL busy_set: got %b/%b want 101", busy0, busy1);
        else pass_cnt++;
        waddr = {6'd0, 6'd3}; wdata = {32'h0, 32'h33}; we = 2'b01;
        #1;
        chk_cnt++;
        if (busy0[0] !== 1'b1)
            $display("FAIL busy_before_clear: got %b want 1", busy0[0]);
        else pass_cnt++;
        tick();
        we = 2'b00;
        #1;
        chk_cnt++;
        if (busy0 !== 3'b000 || busy1 !== 3'b000)
            $display("FAIL busy_clear: got %b/%b want 000", busy0, busy1);
        else pass_cnt++;
        // Reserve and write on the same edge: reserve wins.
        rsv_valid = 1'b1; rsv_addr = 6'd3; we = 2'b01;
        tick();
        #1;
        chk_cnt++;
        if (busy0[0] !== 1'b1 || busy1[0] !== 1'b1 || conf0 !== 1'b0)
            $display("FAIL rsv_wins: got busy %b/%b conf %b want 1/1 conf 0", busy0[0], busy1[0], conf0);
        else pass_cnt++;
        // Already busy but cleared the same cycle: no conflict.
        tick();
        rsv_valid = 1'b0; we = 2'b00;
        #1;
        chk_cnt++;
        if (busy0[0] !== 1'b1 || conf0 !== 1'b0 || conf1 !== 1'b0)
            $display("FAIL rsv_cleared_no_conf: got busy %b conf %b/%b want 1 conf 0", busy0[0], conf0, conf1);
        else pass_cnt++;
        we = 2'b01;
        tick();
        we = 2'b00;
    endtask

    task automatic test_conflict();
        rsv_valid = 1'b1; rsv_addr = 6'd4;
        tick();
        chk_cnt++;
        if (conf0 !== 1'b0 || conf1 !== 1'b0)
            $display("FAIL conf_first: got %b/%b want 0", conf0, conf1);
        else pass_cnt++;
        tick();
        rsv_valid = 1'b0;
        chk_cnt++;
        if (conf0 !== 1'b1 || conf1 !== 1'b1)
            $display("FAIL conf_pulse: got %b/%b want 1", conf0, conf1);
        else pass_cnt++;
        // Write elsewhere leaves entry 4 busy.
        set_raddr(6'd4, 6'd5, 6'd0);
        waddr = {6'd0, 6'd5}; wdata = {32'h0, 32'hDEADBEEF}; we = 2'b01;
        tick();
        we = 2'b00;
        chk_cnt++;
        if (conf0 !== 1'b0 || busy0 !== 3'b001 || busy1 !== 3'b001)
            $display("FAIL conf_end_busy_keep: got conf %b busy %b/%b want 0 001", conf0, busy0, busy1);
        else pass_cnt++;
        rsv_valid = 1'b1; rsv_addr = 6'd0;
        tick();
        tick();
        rsv_valid = 1'b0;
        chk_cnt++;
        if (conf0 !== 1'b0 || busy0[2] !== 1'b0)
            $display("FAIL rsv_x0: got conf %b busy %b want 0 0", conf0, busy0[2]);
        else pass_cnt++;
    endtask

    task automatic test_fp_bank();
        waddr = {6'd0, 6'd32}; wdata = {32'h0, 32'h3F800000}; we = 2'b01;
        tick();
        we = 2'b00;
        set_raddr(6'd32, 6'd5, 6'd0);
        #1;
        chk_cnt++;
        if (rdata1[31:0] !== 32'h3F800000 || rdata0[31:0] !== 32'h0)
            $display("FAIL fp_f0: got %h/%h want 00000000/3f800000", rdata0[31:0], rdata1[31:0]);
        else pass_cnt++;
        rsv_valid = 1'b1; rsv_addr = 6'd32;
        tick();
        rsv_valid = 1'b0;
        chk_cnt++;
        if (busy1[0] !== 1'b1 || busy0[0] !== 1'b0)
            $display("FAIL fp_busy: got %b/%b want 0/1", busy0[0], busy1[0]);
        else pass_cnt++;
    endtask

    task automatic test_midrun_reset();
        set_raddr(6'd5, 6'd4, 6'd32);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        waddr = {6'd0, 6'd9}; wdata = {32'h0, 32'hFFFF}; we = 2'b01;
        rsv_valid = 1'b1; rsv_addr = 6'd6;
        #1;
        chk_cnt++;
        if (rdata0 !== 96'h0 || rdata1 !== 96'h0 || busy0 !== 3'b0 || busy1 !== 3'b0 || conf0 !== 1'b0 || conf1 !== 1'b0)
            $display("FAIL midrun_reset: got %h/%h busy %b/%b want all 0", rdata0, rdata1, busy0, busy1);
        else pass_cnt++;
        set_raddr(6'd9, 6'd6, 6'd32);
        tick();
        chk_cnt++;
        if (rdata1 !== 96'h0 || busy1 !== 3'b0)
            $display("FAIL reset_hold: got %h busy %b want 0", rdata1, busy1);
        else pass_cnt++;
        we = 2'b00; rsv_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if (rdata0 !== 96'h0 || rdata1 !== 96'h0 || busy1 !== 3'b0)
            $display("FAIL post_reset: got %h/%h busy %b want 0", rdata0, rdata1, busy1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_multi_write();
        test_bypass();
        test_busy();
        test_conflict();
        test_fp_bank();
        test_midrun_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
